// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides, carry-chained
// add/sub, shifts, logic ops and a multi-cycle shift-add multiplier.
module alu_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   input  logic [3:0]       ALU_op_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] ALU_RESULT_o,
   output logic [3:0]       ALU_FLAGS_o
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_LSL = 4'd2;
   localparam logic [3:0] OP_LSR = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_NOT = 4'd6;
   localparam logic [3:0] OP_FWA = 4'd7;
   localparam logic [3:0] OP_ADC = 4'd8;
   localparam logic [3:0] OP_SBC = 4'd9;
   localparam logic [3:0] OP_ASR = 4'd10;
   localparam logic [3:0] OP_XOR = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_reg, state_next;
   logic               out_valid_reg, out_valid_next;
   logic [WIDTH-1:0]   result_reg, result_next;
   logic [3:0]         flags_reg, flags_next;
   logic               cf_reg, cf_next;
   logic [2*WIDTH-1:0] mcand_reg, mcand_next;
   logic [2*WIDTH-1:0] prod_reg, prod_next;
   logic [WIDTH-1:0]   mplier_reg, mplier_next;
   logic [CW-1:0]      count_reg, count_next;

   logic accept;

   assign in_ready_o   = (state_reg == IDLE) && (!out_valid_reg || out_ready_i);
   assign accept       = in_valid_i && in_ready_o;
   assign out_valid_o  = out_valid_reg;
   assign ALU_RESULT_o = result_reg;
   assign ALU_FLAGS_o  = flags_reg;

   logic [WIDTH-1:0] and_v, or_v, xor_v, not_v;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
      assign and_v[gi] = A_i[gi] & B_i[gi];
      assign or_v[gi]  = A_i[gi] | B_i[gi];
      assign xor_v[gi] = A_i[gi] ^ B_i[gi];
      assign not_v[gi] = ~A_i[gi];
   end

   // One adder serves ADD/SUB/ADC/SBC; subtraction inverts B and picks the carry-in.
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic [WIDTH:0]   sum_ext;
   logic             add_v;

   always_comb begin
      add_b   = B_i;
      add_cin = 1'b0;
      case (ALU_op_i)
         OP_SUB:  begin add_b = ~B_i; add_cin = 1'b1;   end
         OP_ADC:  add_cin = cf_reg;
         OP_SBC:  begin add_b = ~B_i; add_cin = cf_reg; end
         default: ;
      endcase
   end

   assign sum_ext = {1'b0, A_i} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
   assign add_v   = (A_i[WIDTH-1] == add_b[WIDTH-1]) && (sum_ext[WIDTH-1] != A_i[WIDTH-1]);

   // Each shifter carries one guard bit so the last bit shifted out lands in it.
   logic [SHW-1:0] shamt;
   logic           shift_big;
   logic [WIDTH:0] lsl_ext, lsr_ext, asr_ext;

   assign shamt     = B_i[SHW-1:0];
   assign shift_big = (32'(shamt) >= 32'(WIDTH));
   assign lsl_ext   = {1'b0, A_i} << shamt;
   assign lsr_ext   = {A_i, 1'b0} >> shamt;
   assign asr_ext   = $signed({A_i, 1'b0}) >>> shamt;

   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v, alu_illegal;
   logic [3:0]       alu_flags;

   always_comb begin
      alu_res     = '0;
      alu_c       = 1'b0;
      alu_v       = 1'b0;
      alu_illegal = 1'b0;
      case (ALU_op_i)
         OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = add_v;
         end
         OP_LSL: if (!shift_big) begin
            alu_res = lsl_ext[WIDTH-1:0];
            alu_c   = lsl_ext[WIDTH];
         end
         OP_LSR: if (!shift_big) begin
            alu_res = lsr_ext[WIDTH:1];
            alu_c   = lsr_ext[0];
         end
         OP_ASR: begin
            if (shift_big) begin
               alu_res = {WIDTH{A_i[WIDTH-1]}};
               alu_c   = A_i[WIDTH-1];
            end else begin
               alu_res = asr_ext[WIDTH:1];
               alu_c   = asr_ext[0];
            end
         end
         OP_AND:  alu_res = and_v;
         OP_OR:   alu_res = or_v;
         OP_NOT:  alu_res = not_v;
         OP_FWA:  alu_res = A_i;
         OP_XOR:  alu_res = xor_v;
         OP_MUL:  ;
         default: alu_illegal = 1'b1;
      endcase
   end

   assign alu_flags = alu_illegal ? 4'b0001
                    : {alu_v, alu_c, alu_res[WIDTH-1], (alu_res == '0)};

   // Final multiply iteration folds its partial product straight into the output.
   logic [2*WIDTH-1:0] mul_addend, mul_sum;
   logic [3:0]         mul_flags;

   assign mul_addend = mplier_reg[0] ? mcand_reg : '0;
   assign mul_sum    = prod_reg + mul_addend;
   assign mul_flags  = {1'b0, (mul_sum[2*WIDTH-1:WIDTH] != '0),
                        mul_sum[WIDTH-1], (mul_sum[WIDTH-1:0] == '0)};

   always_comb begin
      state_next     = state_reg;
      out_valid_next = out_valid_reg;
      result_next    = result_reg;
      flags_next     = flags_reg;
      cf_next        = cf_reg;
      mcand_next     = mcand_reg;
      prod_next      = prod_reg;
      mplier_next    = mplier_reg;
      count_next     = count_reg;

      if (out_valid_reg && out_ready_i)
         out_valid_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (ALU_op_i == OP_MUL) begin
                  state_next  = BUSY;
                  mcand_next  = {{WIDTH{1'b0}}, A_i};
                  mplier_next = B_i;
                  prod_next   = '0;
                  count_next  = CW'(WIDTH);
               end else begin
                  out_valid_next = 1'b1;
                  result_next    = alu_res;
                  flags_next     = alu_flags;
                  cf_next        = alu_flags[2];
               end
            end
         end
         BUSY: begin
            prod_next   = mul_sum;
            mcand_next  = {mcand_reg[2*WIDTH-2:0], 1'b0};
            mplier_next = {1'b0, mplier_reg[WIDTH-1:1]};
            count_next  = count_reg - CW'(1);
            if (count_reg == CW'(1)) begin
               state_next     = IDLE;
               out_valid_next = 1'b1;
               result_next    = mul_sum[WIDTH-1:0];
               flags_next     = mul_flags;
               cf_next        = mul_flags[2];
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg     <= IDLE;
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         flags_reg     <= '0;
         cf_reg        <= 1'b0;
         mcand_reg     <= '0;
         prod_reg      <= '0;
         mplier_reg    <= '0;
         count_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         out_valid_reg <= out_valid_next;
         result_reg    <= result_next;
         flags_reg     <= flags_next;
         cf_reg        <= cf_next;
         mcand_reg     <= mcand_next;
         prod_reg      <= prod_next;
         mplier_reg    <= mplier_next;
         count_reg     <= count_next;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: expectations are queued at accept and
// compared when the output register transfers.
`timescale 1ns/1ps
module tb_alu_pipe;

   logic       clk_i       = 1'b0;
   logic       rst_i       = 1'b1;
   logic       in_valid_i  = 1'b0;
   logic       out_ready_i = 1'b1;
   logic       in_ready_o, out_valid_o;
   logic [7:0] A_i = '0, B_i = '0, ALU_RESULT_o;
   logic [3:0] ALU_op_i = '0, ALU_FLAGS_o;

   typedef struct packed {
      logic [7:0] result;
      logic [3:0] flags;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_xfer   = 0;
   logic tb_cf    = 1'b0;

   alu_pipe #(.WIDTH(8)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .A_i          (A_i),
      .B_i          (B_i),
      .ALU_op_i     (ALU_op_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .ALU_RESULT_o (ALU_RESULT_o),
      .ALU_FLAGS_o  (ALU_FLAGS_o)
   );

   always #5 clk_i = ~clk_i;

   // A transfer happens on the next rising edge, so compare on the falling edge.
   always @(negedge clk_i) begin
      if (!rst_i && out_valid_o && out_ready_i) begin
         n_checks++;
         n_xfer++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got r=%h f=%b, required no output", ALU_RESULT_o, ALU_FLAGS_o);
         end else begin
            mon_e = sb.pop_front();
            if (ALU_RESULT_o !== mon_e.result || ALU_FLAGS_o !== mon_e.flags) begin
               n_fail++;
               $display("FAIL result: got r=%h f=%b, required r=%h f=%b",
                        ALU_RESULT_o, ALU_FLAGS_o, mon_e.result, mon_e.flags);
            end else begin
               $display("xfer r=%h f=%b ok", ALU_RESULT_o, ALU_FLAGS_o);
            end
         end
      end
   end

   // Independent reference for WIDTH=8, written with integer arithmetic.
   function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, output logic [7:0] r, output logic [3:0] f);
      int   t, s, sa, ia, ib;
      logic c, v;
      c  = 1'b0;
      v  = 1'b0;
      r  = '0;
      ia = int'(a);
      ib = int'(b);
      s  = int'(b[3:0]);
      case (op)
         4'd0: begin t = ia + ib;                 r = t[7:0]; c = (t > 255); v = (a[7] == b[7]) && (r[7] != a[7]); end
         4'd1: begin t = ia + (255 - ib) + 1;     r = t[7:0]; c = (t > 255); v = (a[7] != b[7]) && (r[7] != a[7]); end
         4'd8: begin t = ia + ib + int'(cin);     r = t[7:0]; c = (t > 255); v = (a[7] == b[7]) && (r[7] != a[7]); end
         4'd9: begin t = ia + (255 - ib) + int'(cin); r = t[7:0]; c = (t > 255); v = (a[7] != b[7]) && (r[7] != a[7]); end
         4'd2: if (s < 8) begin t = (ia * (1 << s)) % 256; r = t[7:0]; c = (s == 0) ? 1'b0 : a[8 - s]; end
         4'd3: if (s < 8) begin t = ia / (1 << s); r = t[7:0]; c = (s == 0) ? 1'b0 : a[s - 1]; end
         4'd10: begin
            if (s >= 8) begin
               r = a[7] ? 8'hFF : 8'h00;
               c = a[7];
            end else begin
               sa = a[7] ? ia - 256 : ia;
               t  = sa >>> s;
               r  = t[7:0];
               c  = (s == 0) ? 1'b0 : a[s - 1];
            end
         end
         4'd4:  r = a & b;
         4'd5:  r = a | b;
         4'd6:  r = ~a;
         4'd7:  r = a;
         4'd11: r = a ^ b;
         4'd12: begin t = ia * ib; r = t[7:0]; c = (t > 255); end
         default: begin r = '0; f = 4'b0001; return; end
      endcase
      f = {v, c, r[7], (r == 8'h00)};
   endfunction

   task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic [3:0] ef, output int waited);
      exp_t e;
      waited     = 0;
      in_valid_i = 1'b1;
      A_i        = a;
      B_i        = b;
      ALU_op_i   = op;
      @(negedge clk_i);
      while (!in_ready_o) begin
         waited++;
         if (waited > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready_o, waited);
            break;
         end
         @(negedge clk_i);
      end
      if (in_ready_o) begin
         e.result = er;
         e.flags  = ef;
         sb.push_back(e);
         tb_cf = ef[2];
         $display("send op=%0d a=%h b=%h exp r=%h f=%b", op, a, b, er, ef);
      end
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 20) begin
         @(posedge clk_i);
         #1;
         k++;
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk_i);
      #1;
      n_checks++;
      if (out_valid_o !== 1'b0 || ALU_RESULT_o !== 8'h00 || ALU_FLAGS_o !== 4'h0 || in_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b r=%h f=%b rdy=%b, required v=0 r=00 f=0000 rdy=1",
                  out_valid_o, ALU_RESULT_o, ALU_FLAGS_o, in_ready_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_add();
      int w;
      drive(4'd0, 8'h7F, 8'h01, 8'h80, 4'b1010, w);
      n_checks++;
      if (out_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL add_latency: out_valid=%b one edge after accept, required 1", out_valid_o);
      end
      drain();
   endtask

   task automatic test_sub_chain();
      int w;
      drive(4'd1, 8'h05, 8'h05, 8'h00, 4'b0101, w);
      drive(4'd9, 8'h00, 8'h01, 8'hFF, 4'b0010, w);
      drive(4'd8, 8'hFF, 8'h00, 8'hFF, 4'b0010, w);
      drain();
   endtask

   task automatic test_shifts();
      int w;
      drive(4'd2,  8'h81, 8'h01, 8'h02, 4'b0100, w);
      drive(4'd10, 8'h80, 8'h09, 8'hFF, 4'b0110, w);
      drive(4'd3,  8'hF0, 8'h08, 8'h00, 4'b0001, w);
      drive(4'd3,  8'h81, 8'h00, 8'h81, 4'b0010, w);
      drain();
   endtask

   task automatic test_mul();
      int w;
      drive(4'd12, 8'h12, 8'h0F, 8'h0E, 4'b0100, w);
      for (int i = 0; i <= 8; i++) begin
         n_checks++;
         if (i < 8) begin
            if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0) begin
               n_fail++;
               $display("FAIL mul_busy[%0d]: rdy=%b v=%b, required rdy=0 v=0", i, in_ready_o, out_valid_o);
            end
         end else if (out_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_latency: out_valid=%b after edge k+8, required 1", out_valid_o);
         end
         if (i < 8) begin
            @(posedge clk_i);
            #1;
         end
      end
      drive(4'd12, 8'h00, 8'hAB, 8'h00, 4'b0001, w);
      drain();
   endtask

   task automatic test_backpressure();
      int w;
      out_ready_i = 1'b0;
      drive(4'd0, 8'h10, 8'h20, 8'h30, 4'b0000, w);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (out_valid_o !== 1'b1 || ALU_RESULT_o !== 8'h30 || ALU_FLAGS_o !== 4'b0000 || in_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hold[%0d]: got v=%b r=%h f=%b rdy=%b, required v=1 r=30 f=0000 rdy=0",
                     i, out_valid_o, ALU_RESULT_o, ALU_FLAGS_o, in_ready_o);
         end
         @(posedge clk_i);
         #1;
      end
      out_ready_i = 1'b1;
      drive(4'd11, 8'h0F, 8'hFF, 8'hF0, 4'b0010, w);
      n_checks++;
      if (w !== 0 || out_valid_o !== 1'b1 || ALU_RESULT_o !== 8'hF0) begin
         n_fail++;
         $display("FAIL release: waited=%0d v=%b r=%h, required waited=0 v=1 r=f0", w, out_valid_o, ALU_RESULT_o);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int         w, total_wait, xfer_before;
      logic [3:0] op;
      logic [7:0] a, b, er;
      logic [3:0] ef;
      total_wait  = 0;
      xfer_before = n_xfer;
      for (int i = 0; i < 10; i++) begin
         op = 4'($urandom_range(0, 11));
         a  = 8'($urandom_range(0, 255));
         b  = 8'($urandom_range(0, 255));
         model(op, a, b, tb_cf, er, ef);
         drive(op, a, b, er, ef, w);
         total_wait += w;
      end
      @(posedge clk_i);
      #1;
      n_checks++;
      if (total_wait != 0 || (n_xfer - xfer_before) != 10) begin
         n_fail++;
         $display("FAIL stream: stalls=%0d transfers=%0d, required stalls=0 transfers=10",
                  total_wait, n_xfer - xfer_before);
      end
      drain();
   endtask

   task automatic test_reset_mid_mul();
      int  w;
      logic stale;
      drive(4'd0, 8'hFF, 8'h01, 8'h00, 4'b0101, w);
      drain();
      drive(4'd12, 8'h03, 8'h05, 8'h0F, 4'b0000, w);
      repeat (3) @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      n_checks++;
      if (out_valid_o !== 1'b0 || ALU_RESULT_o !== 8'h00 || ALU_FLAGS_o !== 4'h0 || in_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: got v=%b r=%h f=%b rdy=%b, required v=0 r=00 f=0000 rdy=1",
                  out_valid_o, ALU_RESULT_o, ALU_FLAGS_o, in_ready_o);
      end
      sb.delete();
      tb_cf = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      stale = 1'b0;
      repeat (12) begin
         @(posedge clk_i);
         #1;
         if (out_valid_o !== 1'b0) stale = 1'b1;
      end
      n_checks++;
      if (stale) begin
         n_fail++;
         $display("FAIL stale_after_reset: out_valid seen 1, required 0");
      end
      drive(4'd8, 8'h01, 8'h01, 8'h02, 4'b0000, w);
      drive(4'd0, 8'h7F, 8'h01, 8'h80, 4'b1010, w);
      drain();
   endtask

   task automatic test_illegal();
      int w;
      drive(4'd14, 8'h55, 8'hAA, 8'h00, 4'b0001, w);
      drive(4'd13, 8'hFF, 8'hFF, 8'h00, 4'b0001, w);
      drive(4'd15, 8'h80, 8'h01, 8'h00, 4'b0001, w);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_sub_chain();
      test_shifts();
      test_mul();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_mul();
      test_illegal();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
